// File: rtl/hdmi_data_island_decoder_if.sv
// TMDS symbol input and decoded-packet output bundle for the data island decoder.
interface hdmi_data_island_decoder_if;
  logic [9:0]  tmds_0;
  logic [9:0]  tmds_1;
  logic [9:0]  tmds_2;
  logic        in_island;
  logic        packet_valid;
  logic [23:0] header;
  logic [55:0] sub0;
  logic [55:0] sub1;
  logic [55:0] sub2;
  logic [55:0] sub3;
  logic        header_ecc_ok;
  logic [3:0]  sub_ecc_ok;
  logic        error;

  // Symbol source side: drives TMDS, observes decoded packets.
  modport master (
    output tmds_0, tmds_1, tmds_2,
    input  in_island, packet_valid, header, sub0, sub1, sub2, sub3,
    input  header_ecc_ok, sub_ecc_ok, error
  );

  // Decoder side.
  modport slave (
    input  tmds_0, tmds_1, tmds_2,
    output in_island, packet_valid, header, sub0, sub1, sub2, sub3,
    output header_ecc_ok, sub_ecc_ok, error
  );
endinterface

// File: rtl/hdmi_data_island_decoder.sv
// HDMI data island receiver: guard band detection, TERC4 decode, packet
// reassembly and BCH ECC check, one valid pulse per completed packet.
module hdmi_data_island_decoder #(
  parameter int unsigned MAX_PACKETS = 18
) (
  input  logic                        clk_pixel,
  input  logic                        reset,
  hdmi_data_island_decoder_if.slave   bus
);

  localparam int unsigned PKT_W    = $clog2(MAX_PACKETS + 1);
  localparam logic [9:0]  GB       = 10'b0100110011;
  localparam logic [7:0]  ECC_POLY = 8'b1000_0011;
  localparam logic [4:0]  LAST_CNT = 5'd31;
  localparam logic [4:0]  HDR_BITS = 5'd24;
  localparam logic [4:0]  SUB_CYC  = 5'd28;

  typedef enum logic [1:0] {IDLE, LEAD, PACKET, GAP} state_t;

  state_t state, state_nxt;

  logic [4:0]       cnt;
  logic [PKT_W-1:0] pkt;
  logic [31:0]      hdr_asm, hdr_nxt;
  logic [3:0][63:0] sub_asm, sub_nxt;
  logic [7:0]       hdr_e, hdr_e_nxt;
  logic [3:0][7:0]  sub_e, sub_e_nxt;

  logic       ok0, ok1, ok2;
  logic [1:0] hi0;
  logic [3:0] d1, d2;
  logic       gb_c, lead_ok_c;
  logic       cap_c, done_c, err_c, island_c, new_island_c;

  function automatic logic [9:0] terc4_code(input logic [3:0] n);
    case (n)
      4'h0:    terc4_code = 10'b1010011100;
      4'h1:    terc4_code = 10'b1001100011;
      4'h2:    terc4_code = 10'b1011100100;
      4'h3:    terc4_code = 10'b1011100010;
      4'h4:    terc4_code = 10'b0101110001;
      4'h5:    terc4_code = 10'b0100011110;
      4'h6:    terc4_code = 10'b0110001110;
      4'h7:    terc4_code = 10'b0100111100;
      4'h8:    terc4_code = 10'b1011001100;
      4'h9:    terc4_code = 10'b0100111001;
      4'hA:    terc4_code = 10'b0110011100;
      4'hB:    terc4_code = 10'b1011000110;
      4'hC:    terc4_code = 10'b1010001110;
      4'hD:    terc4_code = 10'b1001110001;
      4'hE:    terc4_code = 10'b0101100011;
      default: terc4_code = 10'b1011000011;
    endcase
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] e, input logic d);
    lfsr_step = (e >> 1) ^ ((e[0] ^ d) ? ECC_POLY : 8'h00);
  endfunction

  // TERC4 decode of all three channels; ch0 only needs its upper two bits.
  always_comb begin
    ok0 = 1'b0;
    hi0 = 2'b00;
    ok1 = 1'b0;
    d1  = 4'h0;
    ok2 = 1'b0;
    d2  = 4'h0;
    for (int n = 0; n < 16; n++) begin
      if (bus.tmds_0 == terc4_code(4'(n))) begin
        ok0 = 1'b1;
        hi0 = 2'(n >> 2);
      end
      if (bus.tmds_1 == terc4_code(4'(n))) begin
        ok1 = 1'b1;
        d1  = 4'(n);
      end
      if (bus.tmds_2 == terc4_code(4'(n))) begin
        ok2 = 1'b1;
        d2  = 4'(n);
      end
    end
  end

  assign gb_c      = (bus.tmds_1 == GB) && (bus.tmds_2 == GB);
  assign lead_ok_c = gb_c && ok0 && (hi0 == 2'b11);

  // State register.
  always_ff @(posedge clk_pixel) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-symbol control.
  always_comb begin
    state_nxt    = state;
    cap_c        = 1'b0;
    done_c       = 1'b0;
    err_c        = 1'b0;
    island_c     = bus.in_island;
    new_island_c = 1'b0;
    case (state)
      IDLE: begin
        if (lead_ok_c) state_nxt = LEAD;
      end
      LEAD: begin
        if (lead_ok_c) begin
          state_nxt    = PACKET;
          island_c     = 1'b1;
          new_island_c = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      PACKET: begin
        if (!(ok0 && ok1 && ok2)) begin
          err_c     = 1'b1;
          island_c  = 1'b0;
          state_nxt = IDLE;
        end else begin
          cap_c = 1'b1;
          if (cnt == LAST_CNT) begin
            done_c    = 1'b1;
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        // A data symbol here is cnt=0 of the next packet; trailing guard band ends the island.
        if (ok1 && ok2) begin
          if ((pkt == PKT_W'(MAX_PACKETS)) || !ok0) begin
            err_c     = 1'b1;
            island_c  = 1'b0;
            state_nxt = IDLE;
          end else begin
            cap_c     = 1'b1;
            state_nxt = PACKET;
          end
        end else begin
          err_c     = !gb_c;
          island_c  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Symbol capture into the packet buffers and ECC LFSR update.
  always_comb begin
    hdr_nxt      = hdr_asm;
    hdr_nxt[cnt] = hi0[0];
    hdr_e_nxt    = (cnt < HDR_BITS) ? lfsr_step((cnt == 5'd0) ? 8'h00 : hdr_e, hi0[0]) : hdr_e;
    sub_nxt      = sub_asm;
    sub_e_nxt    = sub_e;
    for (int k = 0; k < 4; k++) begin
      sub_nxt[k][{cnt, 1'b0}] = d1[k];
      sub_nxt[k][{cnt, 1'b1}] = d2[k];
      if (cnt < SUB_CYC) begin
        sub_e_nxt[k] = lfsr_step(lfsr_step((cnt == 5'd0) ? 8'h00 : sub_e[k], d1[k]), d2[k]);
      end
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cnt               <= '0;
      pkt               <= '0;
      hdr_asm           <= '0;
      sub_asm           <= '0;
      hdr_e             <= '0;
      sub_e             <= '0;
      bus.in_island     <= 1'b0;
      bus.packet_valid  <= 1'b0;
      bus.error         <= 1'b0;
      bus.header        <= '0;
      bus.sub0          <= '0;
      bus.sub1          <= '0;
      bus.sub2          <= '0;
      bus.sub3          <= '0;
      bus.header_ecc_ok <= 1'b0;
      bus.sub_ecc_ok    <= '0;
    end else begin
      cnt <= cap_c ? cnt + 5'd1 : 5'd0;
      if (new_island_c)  pkt <= '0;
      else if (done_c)   pkt <= pkt + PKT_W'(1);
      if (cap_c) begin
        hdr_asm <= hdr_nxt;
        sub_asm <= sub_nxt;
        hdr_e   <= hdr_e_nxt;
        sub_e   <= sub_e_nxt;
      end
      bus.in_island    <= island_c;
      bus.packet_valid <= done_c;
      bus.error        <= err_c;
      if (done_c) begin
        bus.header        <= hdr_nxt[23:0];
        bus.sub0          <= sub_nxt[0][55:0];
        bus.sub1          <= sub_nxt[1][55:0];
        bus.sub2          <= sub_nxt[2][55:0];
        bus.sub3          <= sub_nxt[3][55:0];
        bus.header_ecc_ok <= (hdr_nxt[31:24] == hdr_e);
        for (int k = 0; k < 4; k++) begin
          bus.sub_ecc_ok[k] <= (sub_nxt[k][63:56] == sub_e[k]);
        end
      end
    end
  end

endmodule

// File: tb/tb_hdmi_data_island_decoder.sv
// Directed bench for hdmi_data_island_decoder.
module tb_hdmi_data_island_decoder;

  localparam logic [9:0] GB  = 10'b0100110011;
  localparam logic [9:0] CTL = 10'b1101010100;

  logic clk;
  logic reset;

  hdmi_data_island_decoder_if dif ();

  hdmi_data_island_decoder #(.MAX_PACKETS(18)) dut (
    .clk_pixel (clk),
    .reset     (reset),
    .bus       (dif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0, n_valid = 0, n_err = 0, n_isl = 0, n_both = 0, err_cyc = 0;
  int valid_cyc[$];
  logic [23:0]      m_hdr;
  logic [3:0][55:0] m_sub;
  logic             m_hok;
  logic [3:0]       m_sok;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (dif.in_island) n_isl++;
    if (dif.error) begin
      n_err++;
      err_cyc = cyc;
    end
    if (dif.packet_valid && dif.error) n_both++;
    if (dif.packet_valid) begin
      n_valid++;
      valid_cyc.push_back(cyc);
      m_hdr    = dif.header;
      m_sub[0] = dif.sub0;
      m_sub[1] = dif.sub1;
      m_sub[2] = dif.sub2;
      m_sub[3] = dif.sub3;
      m_hok    = dif.header_ecc_ok;
      m_sok    = dif.sub_ecc_ok;
    end
  end

  function automatic logic [9:0] terc4(input logic [3:0] n);
    logic [9:0] t [16];
    t = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
          10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
          10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
          10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    return t[n];
  endfunction

  function automatic logic [7:0] ecc(input logic [63:0] d, input int n);
    logic [7:0] e;
    logic fb;
    e = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = e[0] ^ d[i];
      e  = e >> 1;
      if (fb) e = e ^ 8'h83;
    end
    return e;
  endfunction

  task automatic step(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    dif.tmds_0 = a;
    dif.tmds_1 = b;
    dif.tmds_2 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(CTL, CTL, CTL);
  endtask

  task automatic guard2();
    repeat (2) step(terc4(4'b1100), GB, GB);
  endtask

  // One packet; bad_at injects 3FF on ch1, rst_at pulses reset; either aborts the stream.
  task automatic send_packet(input logic [23:0] hb, input logic [3:0][55:0] sb,
                             input logic [31:0] hflip, input int bad_at, input int rst_at);
    logic [31:0]      h;
    logic [3:0][63:0] s;
    logic [3:0]       n1, n2;
    logic             stop;
    h    = {ecc({40'b0, hb}, 24), hb} ^ hflip;
    for (int k = 0; k < 4; k++) s[k] = {ecc({8'b0, sb[k]}, 56), sb[k]};
    stop = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (!stop) begin
        for (int k = 0; k < 4; k++) begin
          n1[k] = s[k][2*c];
          n2[k] = s[k][2*c+1];
        end
        if (c == bad_at) begin
          step(terc4({1'b0, h[c], 2'b00}), 10'h3FF, terc4(n2));
          stop = 1'b1;
        end else if (c == rst_at) begin
          reset = 1'b1;
          step(terc4({1'b0, h[c], 2'b00}), terc4(n1), terc4(n2));
          step(CTL, CTL, CTL);
          reset = 1'b0;
          stop  = 1'b1;
        end else begin
          step(terc4({1'b0, h[c], 2'b00}), terc4(n1), terc4(n2));
        end
      end
    end
  endtask

  localparam logic [55:0] ACR = 56'h00_18_00_70_62_00_00;

  int bv, be, bi, q0, st;
  logic [3:0][55:0] sb;

  initial begin
    reset      = 1'b1;
    dif.tmds_0 = CTL;
    dif.tmds_1 = CTL;
    dif.tmds_2 = CTL;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_island", 64'(dif.in_island), 0);
    check_eq("rst_valid", 64'(dif.packet_valid), 0);
    check_eq("rst_error", 64'(dif.error), 0);
    check_eq("rst_header", 64'(dif.header), 0);
    check_eq("rst_sub0", 64'(dif.sub0), 0);
    check_eq("rst_sub3", 64'(dif.sub3), 0);
    check_eq("rst_hok", 64'(dif.header_ecc_ok), 0);
    check_eq("rst_sok", 64'(dif.sub_ecc_ok), 0);
    reset = 1'b0;

    // Null packet
    bv = n_valid; be = n_err; bi = n_isl;
    guard2();
    send_packet(24'h0, '0, 32'h0, -1, -1);
    guard2();
    idle(4);
    check_eq("null_valid_cnt", 64'(n_valid - bv), 1);
    check_eq("null_header", 64'(m_hdr), 0);
    for (int k = 0; k < 4; k++) check_eq("null_sub", 64'(m_sub[k]), 0);
    check_eq("null_hok", 64'(m_hok), 1);
    check_eq("null_sok", 64'(m_sok), 4'hF);
    check_eq("null_island_len", 64'(n_isl - bi), 33);
    check_eq("null_err", 64'(n_err - be), 0);

    // ACR packet
    bv = n_valid;
    sb = {4{ACR}};
    guard2();
    send_packet(24'h000001, sb, 32'h0, -1, -1);
    guard2();
    idle(4);
    check_eq("acr_valid_cnt", 64'(n_valid - bv), 1);
    check_eq("acr_header", 64'(m_hdr), 24'h000001);
    check_eq("acr_sub0", 64'(m_sub[0]), ACR);
    check_eq("acr_n", 64'({m_sub[0][35:32], m_sub[0][47:40], m_sub[0][55:48]}), 6144);
    check_eq("acr_cts", 64'({m_sub[0][11:8], m_sub[0][23:16], m_sub[0][31:24]}), 25200);
    check_eq("acr_sub3", 64'(m_sub[3]), ACR);
    check_eq("acr_hok", 64'(m_hok), 1);
    check_eq("acr_sok", 64'(m_sok), 4'hF);

    // Header bit 5 corrupted in transit
    bv = n_valid;
    guard2();
    send_packet(24'h000001, sb, 32'h20, -1, -1);
    guard2();
    idle(6);
    check_eq("ecc_valid_cnt", 64'(n_valid - bv), 1);
    check_eq("ecc_header", 64'(m_hdr), 24'h000021);
    check_eq("ecc_hok", 64'(m_hok), 0);
    check_eq("ecc_sok", 64'(m_sok), 4'hF);
    check_eq("ecc_hold_header", 64'(dif.header), 24'h000021);

    // Three back-to-back packets
    bv = n_valid; be = n_err; q0 = valid_cyc.size();
    guard2();
    st = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      sb = {4{56'h11_2233_4455_6677 + 56'(i)}};
      send_packet(24'h0A0B0C + 24'(i), sb, 32'h0, -1, -1);
    end
    guard2();
    idle(4);
    check_eq("b2b_valid_cnt", 64'(n_valid - bv), 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("b2b_pulse_cycle",
               64'((q0 + i < valid_cyc.size()) ? valid_cyc[q0 + i] - st : -1),
               64'(32 * (i + 1)));
    end
    check_eq("b2b_err", 64'(n_err - be), 0);
    check_eq("b2b_last_header", 64'(m_hdr), 24'h0A0B0E);
    check_eq("b2b_last_sub2", 64'(m_sub[2]), 56'h11_2233_4455_6679);
    check_eq("b2b_sok", 64'(m_sok), 4'hF);

    // Invalid symbol at cnt=10, then a clean island
    bv = n_valid; be = n_err;
    guard2();
    send_packet(24'h000001, sb, 32'h0, 10, -1);
    idle(40);
    check_eq("bad_err_cnt", 64'(n_err - be), 1);
    check_eq("bad_valid_cnt", 64'(n_valid - bv), 0);
    check_eq("bad_in_island", 64'(dif.in_island), 0);
    bv = n_valid;
    sb = {4{ACR}};
    guard2();
    send_packet(24'h000001, sb, 32'h0, -1, -1);
    guard2();
    idle(4);
    check_eq("recover_valid_cnt", 64'(n_valid - bv), 1);
    check_eq("recover_header", 64'(m_hdr), 24'h000001);
    check_eq("recover_hok", 64'(m_hok), 1);

    // Reset at cnt=15
    bv = n_valid; be = n_err;
    guard2();
    send_packet(24'h000001, sb, 32'h0, -1, 15);
    idle(4);
    check_eq("rstmid_valid_cnt", 64'(n_valid - bv), 0);
    check_eq("rstmid_err_cnt", 64'(n_err - be), 0);
    check_eq("rstmid_in_island", 64'(dif.in_island), 0);
    check_eq("rstmid_header", 64'(dif.header), 0);

    // 19 back-to-back packets overflow an 18-packet island
    bv = n_valid; be = n_err;
    guard2();
    for (int i = 0; i < 19; i++) begin
      send_packet(24'(i), '0, 32'h0, -1, -1);
    end
    idle(40);
    check_eq("ovf_valid_cnt", 64'(n_valid - bv), 18);
    check_eq("ovf_err_cnt", 64'(n_err - be), 1);
    check_eq("ovf_last_header", 64'(m_hdr), 17);
    check_eq("ovf_err_after_last",
             64'(err_cyc - valid_cyc[valid_cyc.size() - 1]), 1);
    check_eq("ovf_in_island", 64'(dif.in_island), 0);

    check_eq("valid_err_overlap", 64'(n_both), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_data_island_decoder.md
# hdmi_data_island_decoder

Receive-side decoder for HDMI data islands, sitting directly downstream of the per-channel TMDS symbol stream in the `clk_pixel` domain. It detects data-island guard bands and TERC4-decodes the three channels. It reassembles each 32-symbol packet into its header and four subpackets, checks BCH ECC, and presents each completed packet with a one-cycle valid pulse to packet consumers such as the InfoFrame parser and the audio sample extractor.

## Interface
- `MAX_PACKETS`, default 18: maximum packets per island; one more packet is a protocol error.
- `clk_pixel`  in  1  pixel clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tmds_0`, `tmds_1`, `tmds_2`  in  10 each  one TMDS symbol per channel per cycle.
- `in_island`  out  1  high from the 2nd leading guard band symbol until the island ends.
- `packet_valid`  out  1  one-cycle pulse; packet fields are valid.
- `header`  out  24  HB0 in [7:0], HB1 in [15:8], HB2 in [23:16].
- `sub0`..`sub3`  out  56 each  subpacket data bytes PB0..PB6, LSB-first.
- `header_ecc_ok`  out  1  received header parity matches the computed parity.
- `sub_ecc_ok`  out  4  bit k: subpacket k parity matches.
- `error`  out  1  one-cycle pulse on an aborted island.

## Operation
- **TERC4 decode.** Each channel is decoded combinationally through the 16-entry TERC4 table (0000→1010011100 … 1111→1011000011). A symbol not in the table is invalid. `GB` = 0100110011, which is not a TERC4 code.
- **States.** IDLE, LEAD, PACKET, GAP.
- **IDLE → LEAD:** `tmds_1` = `tmds_2` = GB and ch0 decodes to 11xx.
- **LEAD:** if the same condition holds on the next cycle, go to PACKET with cnt=0, pkt=0 and `in_island`=1. Otherwise return to IDLE with no error.
- **PACKET:** one symbol per cycle, cnt runs 0..31.
  - Header bit[cnt] = ch0 decoded [2].
  - `sub`k bit[2·cnt] = ch1 decoded [k].
  - `sub`k bit[2·cnt+1] = ch2 decoded [k].
  - Any invalid symbol on ch0, ch1 or ch2 pulses `error`, discards the packet and returns to IDLE.
- **End of packet.** At cnt=31:
  - Latch all fields and ECC results and pulse `packet_valid`.
  - pkt increments. Go to GAP.
- **GAP,** one symbol after each packet:
  - If ch1 and ch2 are valid TERC4, this symbol is cnt=0 of the next packet; stay in PACKET.
  - If ch1 = ch2 = GB, it is the first trailing guard band. Drop `in_island` and go to IDLE; the second trailing guard band is ignored.
  - Anything else pulses `error` and goes to IDLE.
  - If pkt = `MAX_PACKETS` and the next symbol is TERC4, pulse `error` and go to IDLE.
- **ECC.** Four per-subpacket LFSRs plus one header LFSR, 8 bits each, cleared at cnt=0.
  - Per data bit d: `e = (e>>1) ^ ((e[0]^d) ? 8'b10000011 : 0)`.
  - Header: data bits 0..23, parity bits 24..31.
  - Subpacket: data bits 0..55, parity bits 56..63.
  - Received parity bit i must equal final `e[i]`. Subpacket LFSRs take 2 bits per cycle, bit 2·cnt first.

## Timing
- Latency: `packet_valid` goes high in the cycle after the rising edge that samples symbol cnt=31.
- Fields hold their values until the next `packet_valid`.
- Back-to-back packets give `packet_valid` pulses exactly 32 cycles apart.
- `in_island` rises in the cycle after the 2nd leading guard band is sampled. It falls in the cycle after the first trailing guard band is sampled.
- `error` and `packet_valid` are never high in the same cycle.
- **Reset values:** every output is 0, the state is IDLE and cnt/pkt/LFSRs are 0.
  - Reset asserted mid-packet discards the partial packet with no `packet_valid` and no `error`.
  - The first leading guard band after reset may be sampled on the first cycle with `reset` low.
- Guard band plus TERC4 decode plus capture is single-cycle. No input registering beyond the state flops.

## Test plan
- **Null packet.** Stimulus: 2 guard bands, then 32 cycles with all channels = 1010011100 (all-zero data, zero parity), then 2 guard bands. Required: one `packet_valid`, `header`=0, `sub0..3`=0, `header_ecc_ok`=1, `sub_ecc_ok`=4'hF, `in_island` spans exactly 33 cycles.
- **ACR packet.** Stimulus: HB0=0x01, N=6144, CTS=25200, with the bench encoder generating ECC. Required: `header`=24'h000001, `sub0`[35:32]/[47:40]/[55:48] give N=6144, all ECC ok.
- **ECC corruption.** Stimulus: the same packet with header bit 5 flipped. Required: `header_ecc_ok`=0, `sub_ecc_ok`=4'hF, `packet_valid` still pulses.
- **Back-to-back packets.** Stimulus: 3 packets with no gap. Required: 3 valid pulses at cycles 32, 64 and 96 after the first packet symbol, and `error` never pulses.
- **Invalid symbol.** Stimulus: `tmds_1`=10'h3FF at cnt=10. Required: `error` pulses once, no `packet_valid`, then a later island decodes normally.
- **Reset mid-packet, then overflow.** Stimulus: `reset` at cnt=15 shows no outputs. Then 19 back-to-back packets give 18 `packet_valid` pulses followed by one `error`.
